count_seg7_display: RTL and testbench
=====================================

Name: count_seg7_display

Overview:
- Consumer of the 6-bit light counter's `cnt` bus; renders the count (0..63) as two decimal digits on the Basys 3 4-digit common-anode 7-segment display.
- Samples the count once per scan frame and converts it to BCD with a sequential double-dabble engine.
- Time-multiplexes the four anodes; all display outputs are active low.

Parameters:
REFRESH_DIV, 100000, clk cycles each digit is lit (1 kHz per digit at 100 MHz); must be >= 8
BLANK_LZ, 1, 1 = blank the tens digit when it is 0; 0 = show a leading zero

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  asynchronous, active-low reset
cnt  input  6  unsigned binary count to display
freeze  input  1  1 = keep the currently displayed value and skip new samples
seg  output  7  segment cathodes, active low, seg[6:0] = g,f,e,d,c,b,a
dp  output  1  decimal point, active low, held 1 (off)
an  output  4  digit anodes, active low, an[0] = rightmost digit
busy  output  1  BCD conversion in progress

Behaviour:
- Reset (rst=0, async):
  - Outputs: an=4'b1111, seg=7'b1111111, dp=1, busy=0.
  - Internal state: prescaler=0, digit index=0, tens=0, ones=0, FSM=IDLE.
  - A conversion in progress is aborted with no commit.
- Prescaler and scan:
  - The prescaler counts 0..REFRESH_DIV-1 and wraps.
  - At the terminal count, the digit index advances 0->1->2->3->0.
  - wrap = terminal count while index==3.
- Outputs are registered and reflect the current index one cycle later:
  - index 0: an=1110, seg=enc(ones).
  - index 1: an=1101, seg=enc(tens); if BLANK_LZ=1 and tens==0, then an=1111 and seg=1111111.
  - index 2 and 3: an=1111, seg=1111111. These digits stay dark but keep the scan at 1/4 duty.
- Segment encoding, seg[6:0] gfedcba:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- Conversion start: a start event is generated on
  - the first clk edge after rst deasserts, and
  - every wrap.
  - A start while freeze=1 is ignored.
- Conversion FSM (IDLE, SHIFT, COMMIT):
  - IDLE: on start, capture cnt into the shadow register, clear the BCD working register, go to SHIFT, set busy=1.
  - SHIFT: exactly 6 cycles, one shift per cycle. Each cycle, first add 3 to any BCD nibble >= 5, then shift left with the shadow MSB entering the BCD register.
  - COMMIT: one cycle. Load tens/ones from the BCD register, set busy=0, return to IDLE.
  - Total latency: 8 cycles from the start edge until the new digits reach the display registers; seg shows them at the next lit phase of each digit.
- Displayed digits never change outside COMMIT; there is no tearing within a frame.
- Changes on cnt during SHIFT are ignored; only the captured value is converted.
- REFRESH_DIV >= 8 guarantees a conversion completes before the next wrap, so a start never arrives while busy.
- Value range: 0..63 maps to tens 0..6 and ones 0..9. No overflow is possible, and no invalid BCD digit can reach the encoder.
- freeze:
  - 1 blocks new captures; the scan continues, showing the held tens/ones.
  - freeze rising during SHIFT does not abort that conversion.
- dp is held 1 at all times, including reset.

Test Plan (REFRESH_DIV=8, so each digit is lit 8 cycles and a frame is 32 cycles):
- Reset with cnt=42, release rst -> busy=1 for cycles 1..7 after release; once index 0 is lit: an=1110, seg=0100100 (2); at index 1: an=1101, seg=0011001 (4); at index 2/3: an=1111.
- cnt=5, BLANK_LZ=1, after one frame -> index 0: seg=0010010 (5); index 1: an=1111, seg=1111111. Repeat with BLANK_LZ=0 -> index 1: an=1101, seg=1000000 (0).
- cnt=63 then cnt=0 -> shows 6,3 (0000010, 0110000); after the next wrap plus 8 cycles shows ones=0; tens is blanked.
- freeze=1 with 27 displayed, change cnt to 50 across 3 frames -> display stays 2,7 and busy stays 0; drop freeze -> after the next wrap plus 8 cycles shows 5,0.
- Change cnt from 19 to 33 during the SHIFT cycles of a conversion -> commits 1,9; the next frame shows 3,3.
- Assert rst during SHIFT -> immediately an=1111, seg=1111111, busy=0; after release, the current cnt is converted within 8 cycles.

Source files
------------

// File: rtl/count_seg7_display_if.sv
// Count-to-display bundle: binary count and freeze in,
// multiplexed 7-segment drive and busy flag out.
interface count_seg7_display_if;
    logic [5:0] cnt;
    logic       freeze;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       busy;

    modport master (
        output cnt,
        output freeze,
        input  seg,
        input  dp,
        input  an,
        input  busy
    );

    modport slave (
        input  cnt,
        input  freeze,
        output seg,
        output dp,
        output an,
        output busy
    );
endinterface

// File: rtl/count_seg7_display.sv
// Two-digit decimal view of a 6-bit count on a multiplexed
// common-anode 7-segment display, with a double-dabble BCD engine.
module count_seg7_display #(
    parameter int REFRESH_DIV = 100000,
    parameter bit BLANK_LZ    = 1'b1
) (
    input logic                 clk,
    input logic                 rst,
    count_seg7_display_if.slave bus
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] PRE_TC = PW'(REFRESH_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    idx_q, idx_d;
    logic          started_q;
    logic [5:0]    shadow_q;
    logic [7:0]    bcd_q, bcd_adj;
    logic [2:0]    sh_q;
    logic [3:0]    tens_q, ones_q;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          tc, wrap, start, busy;

    function automatic logic [6:0] enc(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        tc    = (pre_q == PRE_TC);
        wrap  = tc && (idx_q == 2'd3);
        // first edge out of reset behaves like a wrap
        start = (!started_q || wrap) && !bus.freeze;
        pre_d = tc ? '0 : pre_q + PW'(1);
        idx_d = tc ? idx_q + 2'd1 : idx_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q     <= '0;
            idx_q     <= 2'd0;
            started_q <= 1'b0;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            started_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (sh_q == 3'd5) state_d = COMMIT;
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q != IDLE);
    end

    always_comb begin
        bcd_adj = bcd_q;
        if (bcd_q[3:0] >= 4'd5) bcd_adj[3:0] = bcd_q[3:0] + 4'd3;
        if (bcd_q[7:4] >= 4'd5) bcd_adj[7:4] = bcd_q[7:4] + 4'd3;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shadow_q <= 6'd0;
            bcd_q    <= 8'd0;
            sh_q     <= 3'd0;
            tens_q   <= 4'd0;
            ones_q   <= 4'd0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start) begin
                        shadow_q <= bus.cnt;
                        bcd_q    <= 8'd0;
                        sh_q     <= 3'd0;
                    end
                end
                SHIFT: begin
                    bcd_q    <= {bcd_adj[6:0], shadow_q[5]};
                    shadow_q <= {shadow_q[4:0], 1'b0};
                    sh_q     <= sh_q + 3'd1;
                end
                COMMIT: begin
                    tens_q <= bcd_q[7:4];
                    ones_q <= bcd_q[3:0];
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
        unique case (1'b1)
            (idx_q == 2'd0): begin
                an_d  = 4'b1110;
                seg_d = enc(ones_q);
            end
            (idx_q == 2'd1): begin
                if (!(BLANK_LZ && (tens_q == 4'd0))) begin
                    an_d  = 4'b1101;
                    seg_d = enc(tens_q);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            an_q  <= 4'b1111;
            seg_q <= 7'b1111111;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
        end
    end

    assign bus.seg  = seg_q;
    assign bus.an   = an_q;
    assign bus.dp   = 1'b1;
    assign bus.busy = busy;
endmodule

// File: tb/tb_count_seg7_display.sv
// Randomized bench for count_seg7_display: two instances
// (leading-zero blanking on and off) against a timeline model.
module tb_count_seg7_display;
  localparam int RD = 8;
  localparam int FR = 4 * RD;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [5:0] cnt_v;
  logic frz_v;

  count_seg7_display_if b1 ();
  count_seg7_display_if b0 ();

  assign b1.cnt = cnt_v;
  assign b1.freeze = frz_v;
  assign b0.cnt = cnt_v;
  assign b0.freeze = frz_v;

  count_seg7_display #(
    .REFRESH_DIV(RD),
    .BLANK_LZ(1'b1)
  ) u1 (
    .clk(clk),
    .rst(rst),
    .bus(b1.slave)
  );

  count_seg7_display #(
    .REFRESH_DIV(RD),
    .BLANK_LZ(1'b0)
  ) u0 (
    .clk(clk),
    .rst(rst),
    .bus(b0.slave)
  );

  always #5 clk = ~clk;

  int total;
  int passed;
  int k;
  int disp;
  int pend_val;
  int pend_edge;
  int busy_lo;
  int busy_hi;
  logic [6:0] tab [10];
  logic [5:0] lst [8];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp)
      $display("FAIL %s k=%0d got=%0h exp=%0h", tag, k, got, exp);
    else
      passed++;
  endtask

  task automatic model_reset();
    k = 0;
    disp = 0;
    pend_val = 0;
    pend_edge = -1;
    busy_lo = -1;
    busy_hi = -2;
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_an1"}, 32'(b1.an), 32'hF);
    chk({tag, "_seg1"}, 32'(b1.seg), 32'h7F);
    chk({tag, "_busy1"}, 32'(b1.busy), 32'h0);
    chk({tag, "_dp1"}, 32'(b1.dp), 32'h1);
    chk({tag, "_an0"}, 32'(b0.an), 32'hF);
    chk({tag, "_seg0"}, 32'(b0.seg), 32'h7F);
    chk({tag, "_busy0"}, 32'(b0.busy), 32'h0);
    chk({tag, "_dp0"}, 32'(b0.dp), 32'h1);
  endtask

  task automatic step();
    int idx;
    int tens;
    int ones;
    logic [3:0] a1, a0;
    logic [6:0] s1, s0;
    logic bz;
    @(posedge clk);
    #1;
    k++;
    idx = ((k - 1) / RD) % 4;
    tens = disp / 10;
    ones = disp % 10;
    a1 = 4'hF; s1 = 7'h7F;
    a0 = 4'hF; s0 = 7'h7F;
    if (idx == 0) begin
      a1 = 4'b1110; s1 = tab[ones];
      a0 = 4'b1110; s0 = tab[ones];
    end else if (idx == 1) begin
      a0 = 4'b1101; s0 = tab[tens];
      if (tens != 0) begin
        a1 = 4'b1101; s1 = tab[tens];
      end
    end
    if (k == pend_edge) disp = pend_val;
    if ((k == 1 || (k - 1) % FR == FR - 1) && !frz_v) begin
      pend_val = int'(cnt_v);
      pend_edge = k + 7;
      busy_lo = k;
      busy_hi = k + 6;
    end
    bz = (k >= busy_lo) && (k <= busy_hi);
    chk("an1", 32'(b1.an), 32'(a1));
    chk("seg1", 32'(b1.seg), 32'(s1));
    chk("an0", 32'(b0.an), 32'(a0));
    chk("seg0", 32'(b0.seg), 32'(s0));
    chk("busy1", 32'(b1.busy), 32'(bz));
    chk("busy0", 32'(b0.busy), 32'(bz));
    chk("dp1", 32'(b1.dp), 32'h1);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b0;
    #1;
    chk_rst("rst_async");
    repeat (n) @(posedge clk);
    #1;
    chk_rst("rst_hold");
    rst = 1'b1;
    model_reset();
  endtask

  logic rst_seg;
  logic did;
  int ofs;

  initial begin
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000};
    lst = '{6'd42, 6'd5, 6'd63, 6'd0, 6'd27, 6'd50, 6'd50, 6'd19};
    total = 0;
    passed = 0;
    cnt_v = 6'd42;
    frz_v = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_rst("por");
    rst = 1'b1;
    for (int s = 0; s < 40; s++) begin
      cnt_v = (s < 8) ? lst[s] : 6'($urandom_range(0, 63));
      frz_v = (s == 5) ? 1'b1
            : (s >= 9) ? 1'($urandom_range(0, 3) == 0) : 1'b0;
      rst_seg = (s == 8) || (s > 8 && s % 5 == 0);
      did = 1'b0;
      ofs = $urandom_range(1, 5);
      for (int c = 0; c < 100; c++) begin
        step();
        if (rst_seg && !did && k > FR && (k % FR) == ofs) begin
          did = 1'b1;
          do_reset($urandom_range(1, 3));
        end else if (s == 7 && c >= 40 && (k % FR) == 2) begin
          cnt_v = 6'd33;
        end else if (s >= 8 && $urandom_range(0, 15) == 0) begin
          cnt_v = 6'($urandom_range(0, 63));
        end
        if (s >= 9 && $urandom_range(0, 63) == 0) frz_v = ~frz_v;
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
